pe_operand_feeder: RTL and testbench
====================================

PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, as the operand element width.
REQ-002 The block SHALL take parameter PE_LATENCY, default 4, as the downstream dot-product PE latency in cycles (range 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-low reset.
REQ-005 The block SHALL have ports wr_en input 1, wr_sel input 1 (0=A, 1=B), wr_row input 2, wr_col input 2 and wr_data input DATA_W, forming the matrix load port.
REQ-006 The block SHALL have ports start input 1, busy output 1 and done output 1, forming the job control.
REQ-007 The block SHALL have ports a1..a4 output DATA_W and b1..b4 output DATA_W, the operand lanes to the PE.
REQ-008 The block SHALL have ports issue_valid output 1, issue_row output 2 and issue_col output 2, the operand-set tag.
REQ-009 The block SHALL have ports res_valid output 1, res_row output 2 and res_col output 2, the tag aligned to PE output c.

Function
REQ-010 The block SHALL store two 4x4 matrices, A and B, of DATA_W elements in registers.
REQ-011 When wr_en=1 and busy=0, the block SHALL write wr_data into A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the clock edge; writes while busy=1 SHALL be ignored.
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DRAIN; busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.
REQ-013 In IDLE, start=1 SHALL move the FSM to RUN and clear the issue counter; start while busy=1 SHALL be ignored.
REQ-014 In RUN, the block SHALL issue one operand set per cycle for index n=0..15, with i=n[3:2] and j=n[1:0] (row-major).
REQ-015 For each issued set, ak SHALL equal A[i][k-1] and bk SHALL equal B[k-1][j] for k=1..4, with issue_valid=1, issue_row=i and issue_col=j, all driven from registers.
REQ-016 The first issue_valid SHALL occur in the cycle after start is sampled, and the 16 issues SHALL occupy 16 consecutive cycles.
REQ-017 After index 15 is issued, the FSM SHALL enter DRAIN.
REQ-018 When issue_valid=0, a1..a4 and b1..b4 SHALL be 0.
REQ-019 res_valid, res_row and res_col SHALL be exact copies of issue_valid, issue_row and issue_col delayed by PE_LATENCY cycles through a shift register that shifts every cycle.
REQ-020 done SHALL pulse for one cycle, coincident with the res_valid of tag (3,3); in the following cycle the FSM SHALL return to IDLE and busy SHALL be 0.
REQ-021 Given start sampled at cycle T, issues SHALL occupy T+1..T+16, results T+1+PE_LATENCY..T+16+PE_LATENCY, and done T+16+PE_LATENCY.
REQ-022 start asserted in the same cycle as done SHALL be ignored; start in the first IDLE cycle after done SHALL be accepted.
REQ-023 The issue counter SHALL not wrap within a job; the cycle after index 15 SHALL issue nothing.

Reset
REQ-024 With rst=0 at a clock edge, the block SHALL enter IDLE and clear the issue counter, the delay line, matrices A and B, a1..a4, b1..b4, issue_valid, issue_row, issue_col, res_valid, res_row, res_col, busy and done to 0.
REQ-025 A reset during RUN or DRAIN SHALL abort the job with no further res_valid or done.

Configuration
REQ-026 The macro PE_FEEDER_STALL_EN SHALL control the stall feature.
REQ-027 With PE_FEEDER_STALL_EN defined, the block SHALL add port stall, input, 1.
REQ-028 With PE_FEEDER_STALL_EN defined, stall=1 in RUN SHALL freeze the issue counter and force issue_valid=0 for that cycle, while the delay line keeps shifting; stall SHALL have no effect in IDLE or DRAIN.
REQ-029 Without PE_FEEDER_STALL_EN, the stall port SHALL be absent and behaviour SHALL be as in REQ-014..REQ-023.

Verification
REQ-030 Load A=identity and B[r][c]=4r+c, start at T -> issues T+1..T+16; at tag (1,2), a1..a4=0,1,0,0 and b1..b4=2,6,10,14; res tags follow at T+5..T+20 with done at T+20.
REQ-031 Load all A and B elements as 255 -> every issue presents a=b=255 on all lanes, and the PE sum checked at each res_valid equals 260100.
REQ-032 Assert start while busy, and attempt a write to A[0][0]=7 while busy -> no restart, A unchanged, and done occurs exactly once at T+20.
REQ-033 Drive rst=0 at T+8 mid-RUN -> the next cycle shows all outputs 0 and busy=0, with no res_valid or done afterward.
REQ-034 With PE_FEEDER_STALL_EN defined, stall=1 for 3 cycles during RUN -> 16 issues with no tag skipped or repeated, and done at T+23.
REQ-035 Assert start in the cycle after done -> a second full job runs with an identical tag sequence.

Source files
------------

// File: rtl/pe_operand_feeder.sv
// Operand feeder for a 4-lane dot-product PE: holds 4x4 matrices A and B and streams
// row(A)/column(B) operand sets in row-major order. The optional stall input is enabled by PE_FEEDER_STALL_EN.
module pe_operand_feeder #(
    parameter int DATA_W     = 8,
    parameter int PE_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [1:0]        wr_row,
    input  logic [1:0]        wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
`ifdef PE_FEEDER_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic [DATA_W-1:0] b1,
    output logic [DATA_W-1:0] b2,
    output logic [DATA_W-1:0] b3,
    output logic [DATA_W-1:0] b4,
    output logic              issue_valid,
    output logic [1:0]        issue_row,
    output logic [1:0]        issue_col,
    output logic              res_valid,
    output logic [1:0]        res_row,
    output logic [1:0]        res_col
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic [1:0] col;
    } tag_t;

    logic [DATA_W-1:0] mat_a [4][4];
    logic [DATA_W-1:0] mat_b [4][4];

    state_t            state;
    logic [3:0]        cnt;
    logic [3:0]        sel_idx;
    logic [DATA_W-1:0] nxt_a [4];
    logic [DATA_W-1:0] nxt_b [4];
    logic              stall_run;

    tag_t              pipe [PE_LATENCY];
    tag_t              issue_tag;
    tag_t              pre_res;

`ifdef PE_FEEDER_STALL_EN
    assign stall_run = stall;
`else
    assign stall_run = 1'b0;
`endif

    // The matrices are plain flops, so a synchronous clear is legal here.
    // NOTE: a RAM-inferred array must never sit in a reset branch; only register arrays may be cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    mat_a[r][c] <= '0;
                    mat_b[r][c] <= '0;
                end
            end
        end else if (wr_en && !busy) begin
            if (wr_sel) mat_b[wr_row][wr_col] <= wr_data;
            else        mat_a[wr_row][wr_col] <= wr_data;
        end
    end

    // Index of the operand set loaded at the coming edge: 0 on job start, else the successor.
    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        sel_idx = (state == IDLE) ? 4'd0 : cnt + 4'd1;
        for (int k = 0; k < 4; k++) begin
            nxt_a[k] = mat_a[sel_idx[3:2]][k];
            nxt_b[k] = mat_b[k][sel_idx[1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            issue_valid <= 1'b0;
            issue_row   <= '0;
            issue_col   <= '0;
            {a1, a2, a3, a4} <= '0;
            {b1, b2, b3, b4} <= '0;
        end else begin
            issue_valid <= 1'b0;
            issue_row   <= '0;
            issue_col   <= '0;
            {a1, a2, a3, a4} <= '0;
            {b1, b2, b3, b4} <= '0;
            done <= (state != IDLE) && pre_res.valid && (pre_res.row == 2'd3) && (pre_res.col == 2'd3);

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        cnt         <= 4'd0;
                        issue_valid <= 1'b1;
                        issue_row   <= sel_idx[3:2];
                        issue_col   <= sel_idx[1:0];
                        {a1, a2, a3, a4} <= {nxt_a[0], nxt_a[1], nxt_a[2], nxt_a[3]};
                        {b1, b2, b3, b4} <= {nxt_b[0], nxt_b[1], nxt_b[2], nxt_b[3]};
                    end
                end
                RUN: begin
                    // cnt holds the index on the outputs; it stops at 15 instead of wrapping.
                    if (cnt == 4'd15) begin
                        state <= DRAIN;
                    end else if (!stall_run) begin
                        cnt         <= sel_idx;
                        issue_valid <= 1'b1;
                        issue_row   <= sel_idx[3:2];
                        issue_col   <= sel_idx[1:0];
                        {a1, a2, a3, a4} <= {nxt_a[0], nxt_a[1], nxt_a[2], nxt_a[3]};
                        {b1, b2, b3, b4} <= {nxt_b[0], nxt_b[1], nxt_b[2], nxt_b[3]};
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign issue_tag = {issue_valid, issue_row, issue_col};

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < PE_LATENCY; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= issue_tag;
            for (int k = 1; k < PE_LATENCY; k++) pipe[k] <= pipe[k-1];
        end
    end

    // pre_res is the tag that reaches the res outputs at the next edge; done is registered from it.
    generate
        if (PE_LATENCY == 1) begin : g_lat1
            assign pre_res = issue_tag;
        end else begin : g_latn
            assign pre_res = pipe[PE_LATENCY-2];
        end
    endgenerate

    assign {res_valid, res_row, res_col} = pipe[PE_LATENCY-1];

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed self-checking bench for pe_operand_feeder; expected values come from a small
// matrix model and the hand-derived issue/result/done timing.
module tb_pe_operand_feeder;

    localparam int DW = 8;
    localparam int L  = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          wr_sel;
    logic [1:0]    wr_row;
    logic [1:0]    wr_col;
    logic [DW-1:0] wr_data;
    logic          start;
`ifdef PE_FEEDER_STALL_EN
    logic          stall;
`endif
    logic          busy, done;
    logic [DW-1:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic          issue_valid, res_valid;
    logic [1:0]    issue_row, issue_col, res_row, res_col;

    int n_checks = 0;
    int n_fail   = 0;
    int ma [4][4];
    int mb [4][4];
    int st_at  = 0;
    int st_len = 0;
    int sum_q [$];

    pe_operand_feeder #(.DATA_W(DW), .PE_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .start(start),
`ifdef PE_FEEDER_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .issue_valid(issue_valid), .issue_row(issue_row), .issue_col(issue_col),
        .res_valid(res_valid), .res_row(res_row), .res_col(res_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input bit sel, input int r, input int c, input int d);
        logic [31:0] rv, cv, dv;
        rv = r; cv = c; dv = d;
        wr_en = 1'b1; wr_sel = sel; wr_row = rv[1:0]; wr_col = cv[1:0]; wr_data = dv[DW-1:0];
        tick();
        wr_en = 1'b0;
        if (sel) mb[r][c] = d;
        else     ma[r][c] = d;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_issue_valid"}, issue_valid, 0);
        check({pfx, "_issue_tag"}, {issue_row, issue_col}, 0);
        check({pfx, "_res_valid"}, res_valid, 0);
        check({pfx, "_res_tag"}, {res_row, res_col}, 0);
        check({pfx, "_a_lanes"}, {a1, a2, a3, a4}, 0);
        check({pfx, "_b_lanes"}, {b1, b2, b3, b4}, 0);
    endtask

    // Expected issue index in cycle T+k, or -1 when nothing is issued.
    function automatic int exp_idx(input int k);
        int n;
        if (k < 1) return -1;
        if (k <= st_at) n = k - 1;
        else if (k <= st_at + st_len) return -1;
        else n = k - 1 - st_len;
        return (n <= 15) ? n : -1;
    endfunction

    function automatic int model_dot(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += ma[n >> 2][k] * mb[k][n & 3];
        return s;
    endfunction

    task automatic run_job(input int rst_at, input bit poke, input bit chk255);
        int done_k, last, ei, er, s;
        int got_a [4];
        int got_b [4];
        done_k = 16 + L + st_len;
        last   = (rst_at > 0) ? rst_at + 4 : done_k + 1;
        sum_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            got_a = '{int'(a1), int'(a2), int'(a3), int'(a4)};
            got_b = '{int'(b1), int'(b2), int'(b3), int'(b4)};
            if (rst_at > 0 && k > rst_at) begin
                check_zero("after_rst");
            end else begin
                ei = exp_idx(k);
                er = exp_idx(k - L);
                check("issue_valid", issue_valid, ei >= 0);
                for (int q = 0; q < 4; q++) begin
                    check("a_lane", got_a[q], (ei >= 0) ? ma[ei >> 2][q] : 0);
                    check("b_lane", got_b[q], (ei >= 0) ? mb[q][ei & 3] : 0);
                end
                if (ei >= 0) begin
                    check("issue_row", issue_row, ei >> 2);
                    check("issue_col", issue_col, ei & 3);
                    s = 0;
                    for (int q = 0; q < 4; q++) s += got_a[q] * got_b[q];
                    sum_q.push_back(s);
                end
                check("res_valid", res_valid, er >= 0);
                if (er >= 0) begin
                    check("res_row", res_row, er >> 2);
                    check("res_col", res_col, er & 3);
                    s = (sum_q.size() > 0) ? sum_q.pop_front() : -1;
                    check("pe_sum", s, model_dot(er));
                    if (chk255) check("pe_sum255", s, 260100);
                end
                check("done", done, k == done_k);
                check("busy", busy, k <= done_k);
            end
            if (k < last) begin
                if (poke && k == 3) begin
                    start = 1'b1;
                    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd7;
                end
                if (poke && k == done_k) start = 1'b1;
                if (k == rst_at) rst = 1'b0;
`ifdef PE_FEEDER_STALL_EN
                stall = (k >= st_at && k < st_at + st_len);
`endif
                tick();
                start = 1'b0;
                wr_en = 1'b0;
                rst   = 1'b1;
`ifdef PE_FEEDER_STALL_EN
                stall = 1'b0;
`endif
            end
        end
        if (rst_at > 0) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    ma[r][c] = 0;
                    mb[r][c] = 0;
                end
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
`ifdef PE_FEEDER_STALL_EN
        stall = 1'b0;
`endif
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
        tick();
        tick();
        check_zero("reset");
        rst = 1'b1;

        // A = identity, B[r][c] = 4r+c
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                write(1'b0, r, c, (r == c) ? 1 : 0);
                write(1'b1, r, c, 4 * r + c);
            end
        run_job(0, 1'b0, 1'b0);
        // start in the first IDLE cycle after done: identical second job
        run_job(0, 1'b0, 1'b0);
        // start and a write to A[0][0] while busy, plus start coincident with done
        run_job(0, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                write(1'b0, r, c, 255);
                write(1'b1, r, c, 255);
            end
`ifdef PE_FEEDER_STALL_EN
        st_at  = 4;
        st_len = 3;
`endif
        run_job(0, 1'b0, 1'b1);
        st_at  = 0;
        st_len = 0;

        // reset mid-RUN, then a job on the cleared matrices
        run_job(8, 1'b0, 1'b0);
        run_job(0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
